// File: rtl/dynode_baseline.sv
// Dynode front end: optional inversion, block-averaged quiet-time baseline,
// and baseline-corrected, zero-clamped 12-bit output for the event detector.
module dynode_baseline #(
  parameter int          AVGSHIFT  = 4,
  parameter int          HOLDOFF   = 32,
  parameter logic [11:0] EXCURSION = 12'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] adc_raw,
  input  logic        invert,
  input  logic        dyn_indet,
  output logic [11:0] dyn_blcor,
  output logic [11:0] baseline,
  output logic        bl_valid,
  output logic        bl_track
);

  localparam int          SW         = 12 + AVGSHIFT;
  localparam logic [7:0]  HOLDOFF_M1 = 8'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [SW-1:0]       sum, sum_acc;
  logic [AVGSHIFT-1:0] blkcnt;
  logic [7:0]          hocnt, hocnt_next;
  logic [11:0]         adc_d;
  logic                accept, discard, exc, blk_full;

  assign sum_acc  = sum + SW'(adc_d);
  assign blk_full = &blkcnt;
  // 13-bit compare so baseline+EXCURSION never wraps
  assign exc = {1'b0, adc_d} > ({1'b0, baseline} + {1'b0, EXCURSION});

  always_comb begin
    state_next = state;
    hocnt_next = hocnt;
    accept     = 1'b0;
    discard    = 1'b0;
    case (state)
      ST_INIT: begin
        accept = 1'b1;
        if (blk_full) state_next = ST_TRACK;
      end
      ST_TRACK: begin
        if (dyn_indet) begin
          discard    = 1'b1;
          state_next = ST_HOLD;
        end else if (exc) begin
          discard = 1'b1;
        end else begin
          accept = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!dyn_indet) begin
          if (HOLDOFF == 0) begin
            state_next = ST_TRACK;
          end else begin
            state_next = ST_HOLDOFF;
            hocnt_next = HOLDOFF_M1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (dyn_indet) state_next = ST_HOLD;
        else if (hocnt == 8'd0) state_next = ST_TRACK;
        else hocnt_next = hocnt - 8'd1;
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_INIT;
      sum       <= '0;
      blkcnt    <= '0;
      hocnt     <= '0;
      adc_d     <= '0;
      baseline  <= '0;
      dyn_blcor <= '0;
      bl_valid  <= 1'b0;
      bl_track  <= 1'b0;
    end else begin
      state     <= state_next;
      hocnt     <= hocnt_next;
      bl_track  <= (state_next == ST_TRACK);
      adc_d     <= invert ? (12'd4095 - adc_raw) : adc_raw;
      // Uses the baseline as it stood before this edge's possible update
      dyn_blcor <= (adc_d >= baseline) ? (adc_d - baseline) : 12'd0;
      if (accept) begin
        if (blk_full) begin
          baseline <= sum_acc[SW-1:AVGSHIFT];
          sum      <= '0;
          blkcnt   <= '0;
          bl_valid <= 1'b1;
        end else begin
          sum    <= sum_acc;
          blkcnt <= blkcnt + AVGSHIFT'(1);
        end
      end else if (discard) begin
        sum    <= '0;
        blkcnt <= '0;
      end
    end
  end

endmodule
